// File: rtl/mul_seq_pkg.sv
// Shared constants and helpers for the iterative signed multiplier.
// State encodings are plain 2-bit constants so the control word stays legacy-compatible.
package mul_seq_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // |-2^(WIDTH-1)| wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return twos_neg(v);
    end else begin
      return v;
    end
  endfunction
endpackage

// File: rtl/mul_seq_if.sv
// Start/done handshake and operand/result bus between issuing control logic and mul_seq.
interface mul_seq_if;
  import mul_seq_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] p;
  logic             sig_O;

  modport master (output start, a, b, input busy, ready, done, p, sig_O);
  modport slave  (input start, a, b, output busy, ready, done, p, sig_O);
endinterface

// File: rtl/mul_seq_add_c.sv
// Combinational WIDTH-bit adder with carry out; the single shared adder of the multiplier.
module add_c
  import mul_seq_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

// File: rtl/mul_seq.sv
// Iterative signed multiplier: magnitudes are multiplied by shift-and-add over WIDTH
// iterations, then the sign is applied and signed overflow is judged in a final FIX step.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  mul_seq_if.slave  bus
);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] MAG_MAX  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] MAG_MIN  = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic               neg_q,    neg_d;
  logic [WIDTH-1:0]   p_q,      p_d;
  logic               sig_o_q,  sig_o_d;
  logic               done_q,   done_d;
  logic               busy_q,   busy_d;
  logic               ready_q,  ready_d;

  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH-1:0]   sum_s;
  logic               cout_s;
  logic [2*WIDTH-1:0] m_s;

  assign addend_s = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
  assign m_s      = {acc_hi_q, mplier_q};

  add_c u_add (
    .a_i    (acc_hi_q),
    .b_i    (addend_s),
    .sum_o  (sum_s),
    .cout_o (cout_s)
  );

  // Next-state logic: accept, iterate, then sign-correct and flag overflow.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_hi_d = acc_hi_q;
    neg_d    = neg_q;
    p_d      = p_q;
    sig_o_d  = sig_o_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_d  = abs_mag(bus.a);
          mplier_d = abs_mag(bus.b);
          neg_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          acc_hi_d = {WIDTH{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
          state_d  = ST_CALC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CALC: begin
        // The carry re-enters at the top as {carry, acc_hi, mplier} shifts right.
        acc_hi_d = {cout_s, sum_s[WIDTH-1:1]};
        mplier_d = {sum_s[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FIX: begin
        p_d     = neg_q ? twos_neg(m_s[WIDTH-1:0]) : m_s[WIDTH-1:0];
        sig_o_d = neg_q ? (m_s > MAG_MIN) : (m_s > MAG_MAX);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_hi_q <= {WIDTH{1'b0}};
      neg_q    <= 1'b0;
      p_q      <= {WIDTH{1'b0}};
      sig_o_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_hi_q <= acc_hi_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
      sig_o_q  <= sig_o_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.p     = p_q;
  assign bus.sig_O = sig_o_q;
endmodule

// File: tb/tb_mul_seq.sv
// Directed and random self-checking bench for mul_seq.
module tb_mul_seq;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   cyc;

  mul_seq_if bus ();

  mul_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic        ov;
  } vec_t;

  vec_t vecs [12] = '{
    '{32'd3,          32'd4,          32'd12,         1'b0},
    '{32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6,   1'b0},
    '{32'hFFFFFFFB,   32'hFFFFFFFB,   32'd25,         1'b0},
    '{32'h00010000,   32'h00010000,   32'h00000000,   1'b1},
    '{32'h80000000,   32'd1,          32'h80000000,   1'b0},
    '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1},
    '{32'd0,          32'hFFFFFFF7,   32'd0,          1'b0},
    '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   1'b0},
    '{32'h7FFFFFFF,   32'hFFFFFFFF,   32'h80000001,   1'b0},
    '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0},
    '{32'h40000000,   32'd2,          32'h80000000,   1'b1},
    '{32'hC0000000,   32'd2,          32'h80000000,   1'b0}
  };

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One operation from an idle DUT; lat counts edges after the accepting edge until done.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] pv, output logic ov,
                       output int lat, output logic busy_ok, output logic busy_end);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 100) begin
      busy_ok &= bus.busy;
      @(posedge clk); #1;
      lat++;
    end
    pv = bus.p;
    ov = bus.sig_O;
    busy_end = bus.busy;
  endtask

  initial begin
    logic [31:0] pv;
    logic        ov;
    int          lat;
    logic        bok;
    logic        bend;
    int          dones;
    int          t1;
    int          t2;
    logic [31:0] p1;
    longint      sa;
    longint      sb;
    longint      prod;
    logic [31:0] ra;
    logic [31:0] rb;

    n_chk = 0; n_pass = 0; cyc = 0;
    rst_n = 1'b0; bus.start = 1'b0; bus.a = 32'd0; bus.b = 32'd0;
    #12;
    check("rst_busy",  {63'd0, bus.busy},  64'd0);
    check("rst_ready", {63'd0, bus.ready}, 64'd1);
    check("rst_done",  {63'd0, bus.done},  64'd0);
    check("rst_p",     {32'd0, bus.p},     64'd0);
    check("rst_sig",   {63'd0, bus.sig_O}, 64'd0);
    #10 rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, pv, ov, lat, bok, bend);
      check($sformatf("dir%0d_p", i),   {32'd0, pv}, {32'd0, vecs[i].p});
      check($sformatf("dir%0d_ov", i),  {63'd0, ov}, {63'd0, vecs[i].ov});
      check($sformatf("dir%0d_lat", i), 64'(lat),    64'd33);
      check($sformatf("dir%0d_busy", i), {62'd0, bok, bend}, 64'd2);
    end

    // Start pulse during an operation must be ignored.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 32'd3; bus.b = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd100;
    @(posedge clk); #1 bus.start = 1'b0;
    dones = 0; p1 = 32'hDEADBEEF;
    for (int k = 0; k < 60; k++) begin
      if (bus.done) begin dones++; p1 = bus.p; end
      @(posedge clk); #1;
    end
    check("ign_dones", 64'(dones), 64'd1);
    check("ign_p",     {32'd0, p1}, 64'd12);

    // Start held high: second operation accepted in the done cycle.
    bus.start = 1'b1; bus.a = 32'd2; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.a = 32'd7; bus.b = 32'hFFFFFFFD;
    lat = 0;
    while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
    t1 = cyc; p1 = bus.p;
    @(posedge clk); #1;
    lat = 0;
    while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
    t2 = cyc; pv = bus.p;
    bus.start = 1'b0;
    check("b2b_p1",  {32'd0, p1}, 64'd10);
    check("b2b_p2",  {32'd0, pv}, {32'd0, 32'hFFFFFFEB});
    check("b2b_gap", 64'(t2 - t1), 64'd34);
    repeat (40) @(posedge clk);

    // Asynchronous reset mid-operation.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mrst_busy", {63'd0, bus.busy},  64'd0);
    check("mrst_p",    {32'd0, bus.p},     64'd0);
    check("mrst_sig",  {63'd0, bus.sig_O}, 64'd0);
    dones = 0;
    repeat (3) begin @(posedge clk); #1; dones += int'(bus.done); end
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; dones += int'(bus.done); end
    check("mrst_nodone", 64'(dones), 64'd0);
    do_op(32'd2, 32'd3, pv, ov, lat, bok, bend);
    check("post_rst_p",   {32'd0, pv}, 64'd6);
    check("post_rst_lat", 64'(lat),    64'd33);

    // Random signed operands against a 64-bit product.
    for (int r = 0; r < 1000; r++) begin
      ra = $urandom;
      rb = $urandom;
      if (r % 4 == 1) ra = $urandom_range(0, 200) - 100;
      if (r % 4 == 2) rb = $urandom_range(0, 200) - 100;
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      prod = sa * sb;
      do_op(ra, rb, pv, ov, lat, bok, bend);
      check("rnd_p",  {32'd0, pv}, {32'd0, prod[31:0]});
      check("rnd_ov", {63'd0, ov},
            {63'd0, (prod > 64'sd2147483647) || (prod < -64'sd2147483648)});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
